// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port, variable-latency memory bus between the fetch and data ports.
// Data has fixed priority, fetch has an anti-starvation override, and hung transfers time out.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    output logic                    if_valid_o,
    output logic                    if_stallreq_o,
    input  logic                    dm_req_i,
    input  logic                    dm_we_i,
    input  logic [DATA_WIDTH/8-1:0] dm_be_i,
    input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
    input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
    output logic [DATA_WIDTH-1:0]   dm_rdata_o,
    output logic                    dm_valid_o,
    output logic                    dm_stallreq_o,
    output logic                    bus_req_o,
    output logic                    bus_we_o,
    output logic [DATA_WIDTH/8-1:0] bus_be_o,
    output logic [ADDR_WIDTH-1:0]   bus_addr_o,
    output logic [DATA_WIDTH-1:0]   bus_wdata_o,
    input  logic                    bus_ack_i,
    input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
    output logic                    bus_err_o
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned SC_WIDTH = 4;
    localparam int unsigned TO_WIDTH = 10;
    localparam logic [SC_WIDTH-1:0] STARVE_MAX = SC_WIDTH'(STARVE_LIMIT);
    localparam logic [TO_WIDTH-1:0] TO_MAX     = TO_WIDTH'(TIMEOUT_CYCLES);
    localparam bit                  TO_EN      = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [SC_WIDTH-1:0]   starve_q, starve_d;
    logic [TO_WIDTH-1:0]   wait_q, wait_d;
    logic                  cancel_q, cancel_d;

    logic                  bus_req_q, bus_req_d;
    logic                  bus_we_q, bus_we_d;
    logic [BE_WIDTH-1:0]   bus_be_q, bus_be_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic                  bus_err_q, bus_err_d;
    logic                  if_valid_q, if_valid_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic                  dm_valid_q, dm_valid_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;

    logic                  if_want;
    logic                  dm_want;
    logic                  grant_if;
    logic                  grant_dm;
    logic                  timed_out;
    logic                  done;
    logic [TO_WIDTH-1:0]   wait_inc;
    logic [DATA_WIDTH-1:0] result;

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            wait_q      <= '0;
            cancel_q    <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_err_q   <= 1'b0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_valid_q  <= 1'b0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            cancel_q    <= cancel_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_err_q   <= bus_err_d;
            if_valid_q  <= if_valid_d;
            if_rdata_q  <= if_rdata_d;
            dm_valid_q  <= dm_valid_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    // Arbitration, transfer tracking and completion
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        cancel_d    = cancel_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_err_d   = 1'b0;
        if_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_valid_d  = 1'b0;
        dm_rdata_d  = dm_rdata_q;

        // A port completing this cycle still shows its old request; ignore it
        if_want   = if_req_i & ~if_valid_q;
        dm_want   = dm_req_i & ~dm_valid_q;
        grant_if  = if_want & (~dm_want | (starve_q == STARVE_MAX));
        grant_dm  = dm_want & ~grant_if;
        wait_inc  = wait_q + TO_WIDTH'(1);
        timed_out = TO_EN && !bus_ack_i && (wait_inc == TO_MAX);
        done      = bus_ack_i | timed_out;
        result    = timed_out ? '0 : bus_rdata_i;

        unique case (state_q)
            IDLE: begin
                if (!if_req_i || grant_if) begin
                    starve_d = '0;
                end else if (grant_dm && (starve_q != STARVE_MAX)) begin
                    starve_d = starve_q + SC_WIDTH'(1);
                end
                if (grant_if) begin
                    state_d     = BUSY_IF;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_be_d    = '1;
                    bus_addr_d  = if_addr_i;
                    bus_wdata_d = '0;
                    cancel_d    = flush_i;
                    wait_d      = '0;
                end else if (grant_dm) begin
                    state_d     = BUSY_DM;
                    bus_req_d   = 1'b1;
                    bus_we_d    = dm_we_i;
                    bus_be_d    = dm_be_i;
                    bus_addr_d  = dm_addr_i;
                    bus_wdata_d = dm_wdata_i;
                    wait_d      = '0;
                end
            end
            BUSY_IF: begin
                if (flush_i) begin
                    cancel_d = 1'b1;
                end
                if (done) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    bus_err_d = timed_out;
                    cancel_d  = 1'b0;
                    if (!(cancel_q || flush_i)) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = result;
                    end
                end else if (TO_EN) begin
                    wait_d = wait_inc;
                end
            end
            BUSY_DM: begin
                if (done) begin
                    state_d    = IDLE;
                    bus_req_d  = 1'b0;
                    bus_err_d  = timed_out;
                    dm_valid_d = 1'b1;
                    dm_rdata_d = result;
                end else if (TO_EN) begin
                    wait_d = wait_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign if_rdata_o    = if_rdata_q;
    assign if_valid_o    = if_valid_q;
    assign dm_rdata_o    = dm_rdata_q;
    assign dm_valid_o    = dm_valid_q;
    assign bus_req_o     = bus_req_q;
    assign bus_we_o      = bus_we_q;
    assign bus_be_o      = bus_be_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_wdata_o   = bus_wdata_q;
    assign bus_err_o     = bus_err_q;

    // Stall requests follow the live request and the registered completion pulse
    assign if_stallreq_o = if_req_i & ~if_valid_q;
    assign dm_stallreq_o = dm_req_i & ~dm_valid_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the arbitration rules.
module tb_mem_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned SL = 4;
    localparam int unsigned TO = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          flush_i;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic [DW-1:0] if_rdata_o;
    logic          if_valid_o;
    logic          if_stallreq_o;
    logic          dm_req_i;
    logic          dm_we_i;
    logic [BW-1:0] dm_be_i;
    logic [AW-1:0] dm_addr_i;
    logic [DW-1:0] dm_wdata_i;
    logic [DW-1:0] dm_rdata_o;
    logic          dm_valid_o;
    logic          dm_stallreq_o;
    logic          bus_req_o;
    logic          bus_we_o;
    logic [BW-1:0] bus_be_o;
    logic [AW-1:0] bus_addr_o;
    logic [DW-1:0] bus_wdata_o;
    logic          bus_ack_i;
    logic [DW-1:0] bus_rdata_i;
    logic          bus_err_o;

    int checks = 0;
    int errors = 0;

    // Model: who owns the bus (0 none, 1 fetch, 2 data) and expected outputs
    int            owner;
    int            waited;
    int            starve;
    bit            cancel;
    logic          e_bus_req, e_bus_we, e_if_valid, e_dm_valid, e_err;
    logic [BW-1:0] e_bus_be;
    logic [AW-1:0] e_bus_addr;
    logic [DW-1:0] e_bus_wdata, e_if_rdata, e_dm_rdata;

    mem_bus_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .STARVE_LIMIT  (SL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_rdata_o   (if_rdata_o),
        .if_valid_o   (if_valid_o),
        .if_stallreq_o(if_stallreq_o),
        .dm_req_i     (dm_req_i),
        .dm_we_i      (dm_we_i),
        .dm_be_i      (dm_be_i),
        .dm_addr_i    (dm_addr_i),
        .dm_wdata_i   (dm_wdata_i),
        .dm_rdata_o   (dm_rdata_o),
        .dm_valid_o   (dm_valid_o),
        .dm_stallreq_o(dm_stallreq_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_be_o     (bus_be_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_ack_i    (bus_ack_i),
        .bus_rdata_i  (bus_rdata_i),
        .bus_err_o    (bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = 0; waited = 0; starve = 0; cancel = 1'b0;
        e_bus_req = 1'b0; e_bus_we = 1'b0; e_bus_be = '0; e_bus_addr = '0;
        e_bus_wdata = '0; e_if_valid = 1'b0; e_if_rdata = '0;
        e_dm_valid = 1'b0; e_dm_rdata = '0; e_err = 1'b0;
    endtask

    // Predict the registered outputs of the next cycle from this cycle's inputs
    task automatic model_step();
        bit            fw, dw, tmo, n_if_v, n_dm_v, n_err;
        int            win;
        logic [DW-1:0] res;
        n_if_v = 1'b0; n_dm_v = 1'b0; n_err = 1'b0;
        if (owner == 0) begin
            fw  = if_req_i && !e_if_valid;
            dw  = dm_req_i && !e_dm_valid;
            win = 0;
            if (fw && (!dw || starve == int'(SL))) win = 1;
            else if (dw) win = 2;
            if (win == 1 || !if_req_i) starve = 0;
            else if (win == 2) starve = (starve + 1 > int'(SL)) ? int'(SL) : starve + 1;
            if (win == 1) begin
                owner = 1; waited = 0; cancel = flush_i;
                e_bus_req = 1'b1; e_bus_we = 1'b0; e_bus_be = '1;
                e_bus_addr = if_addr_i; e_bus_wdata = '0;
            end else if (win == 2) begin
                owner = 2; waited = 0;
                e_bus_req = 1'b1; e_bus_we = dm_we_i; e_bus_be = dm_be_i;
                e_bus_addr = dm_addr_i; e_bus_wdata = dm_wdata_i;
            end
        end else begin
            tmo = 1'b0;
            if (owner == 1 && flush_i) cancel = 1'b1;
            if (!bus_ack_i) begin
                waited++;
                if (TO != 0 && waited == int'(TO)) tmo = 1'b1;
            end
            if (bus_ack_i || tmo) begin
                res = tmo ? '0 : bus_rdata_i;
                e_bus_req = 1'b0;
                n_err = tmo;
                if (owner == 1) begin
                    if (!cancel) begin n_if_v = 1'b1; e_if_rdata = res; end
                    cancel = 1'b0;
                end else begin
                    n_dm_v = 1'b1; e_dm_rdata = res;
                end
                owner = 0;
            end
        end
        e_if_valid = n_if_v; e_dm_valid = n_dm_v; e_err = n_err;
    endtask

    task automatic check_regs();
        chk("bus_req",   64'(bus_req_o),   64'(e_bus_req));
        chk("bus_we",    64'(bus_we_o),    64'(e_bus_we));
        chk("bus_be",    64'(bus_be_o),    64'(e_bus_be));
        chk("bus_addr",  64'(bus_addr_o),  64'(e_bus_addr));
        chk("bus_wdata", 64'(bus_wdata_o), 64'(e_bus_wdata));
        chk("bus_err",   64'(bus_err_o),   64'(e_err));
        chk("if_valid",  64'(if_valid_o),  64'(e_if_valid));
        chk("if_rdata",  64'(if_rdata_o),  64'(e_if_rdata));
        chk("dm_valid",  64'(dm_valid_o),  64'(e_dm_valid));
        chk("dm_rdata",  64'(dm_rdata_o),  64'(e_dm_rdata));
    endtask

    // Inputs for this cycle are already applied; check stalls, advance one clock
    task automatic tick();
        #1;
        chk("if_stall", 64'(if_stallreq_o), 64'(if_req_i && !e_if_valid));
        chk("dm_stall", 64'(dm_stallreq_o), 64'(dm_req_i && !e_dm_valid));
        model_step();
        @(posedge clk_i);
        #1;
        check_regs();
    endtask

    task automatic idle_inputs();
        flush_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_be_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
        bus_ack_i = 1'b0; bus_rdata_i = '0;
    endtask

    task automatic rand_inputs(input int ack_pct);
        if (!if_req_i || e_if_valid) begin
            if_req_i  = ($urandom_range(99) < 50);
            if_addr_i = $urandom & 32'hFFFF_FFFC;
        end
        if (!dm_req_i || e_dm_valid) begin
            dm_req_i   = ($urandom_range(99) < 50);
            dm_we_i    = 1'($urandom_range(1));
            dm_be_i    = BW'($urandom_range(15, 1));
            dm_addr_i  = $urandom;
            dm_wdata_i = $urandom;
        end
        flush_i     = ($urandom_range(99) < 10);
        bus_ack_i   = e_bus_req && ($urandom_range(99) < ack_pct);
        bus_rdata_i = $urandom;
    endtask

    initial begin
        int hi_cnt;
        idle_inputs();
        model_reset();
        rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        check_regs();
        chk("rst_bus_req", 64'(bus_req_o), 64'(0));

        // Fetch only, one wait state
        if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
        tick();
        chk("t1_req_c1", 64'(bus_req_o), 64'(1));
        chk("t1_addr", 64'(bus_addr_o), 64'h10);
        tick();
        chk("t1_stall_c2", 64'(if_stallreq_o), 64'(1));
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0013;
        tick();
        chk("t1_valid_c3", 64'(if_valid_o), 64'(1));
        chk("t1_rdata", 64'(if_rdata_o), 64'h13);
        if_req_i = 1'b0; bus_ack_i = 1'b0;
        tick();
        chk("t1_no_regrant", 64'(bus_req_o), 64'(0));

        // Simultaneous requests: data first
        if_req_i = 1'b1; if_addr_i = 32'h0000_0020;
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'hF;
        dm_addr_i = 32'h0000_0100; dm_wdata_i = 32'hDEAD_BEEF;
        tick();
        chk("t2_dm_we", 64'(bus_we_o), 64'(1));
        chk("t2_dm_wdata", 64'(bus_wdata_o), 64'hDEAD_BEEF);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1234_5678;
        tick();
        chk("t2_dm_valid", 64'(dm_valid_o), 64'(1));
        dm_req_i = 1'b0; bus_ack_i = 1'b0;
        tick();
        chk("t2_if_addr", 64'(bus_addr_o), 64'h20);
        chk("t2_if_we", 64'(bus_we_o), 64'(0));
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0055;
        tick();
        chk("t2_if_rdata", 64'(if_rdata_o), 64'h55);
        if_req_i = 1'b0; bus_ack_i = 1'b0;
        tick();

        // Both ports requesting back to back, zero-wait bus
        for (int i = 0; i < 16; i++) begin
            if (!if_req_i || e_if_valid) begin if_req_i = 1'b1; if_addr_i = 32'h1000 + 32'(i * 4); end
            if (!dm_req_i || e_dm_valid) begin
                dm_req_i = 1'b1; dm_we_i = 1'b1; dm_be_i = 4'h3;
                dm_addr_i = 32'h2000 + 32'(i * 4); dm_wdata_i = 32'(i);
            end
            bus_ack_i = e_bus_req; bus_rdata_i = 32'hA000 + 32'(i);
            tick();
        end
        idle_inputs();
        tick();
        tick();

        // Flushed fetch: transfer finishes, no delivery
        if_req_i = 1'b1; if_addr_i = 32'h0000_0040;
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        tick();
        bus_ack_i = 1'b1; bus_rdata_i = 32'hBAD0_BAD0; if_req_i = 1'b0;
        tick();
        chk("t4_no_valid", 64'(if_valid_o), 64'(0));
        chk("t4_bus_idle", 64'(bus_req_o), 64'(0));
        bus_ack_i = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h0000_0080;
        tick();
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0000_0777;
        tick();
        chk("t4_next_valid", 64'(if_valid_o), 64'(1));
        chk("t4_next_rdata", 64'(if_rdata_o), 64'h777);
        if_req_i = 1'b0; bus_ack_i = 1'b0;
        tick();

        // Data read that never gets an ack
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h200;
        tick();
        hi_cnt = 0;
        for (int i = 0; i < int'(TO); i++) begin
            if (bus_req_o) hi_cnt++;
            tick();
        end
        chk("t5_req_cycles", 64'(hi_cnt), 64'(TO));
        chk("t5_dm_valid", 64'(dm_valid_o), 64'(1));
        chk("t5_dm_rdata", 64'(dm_rdata_o), 64'(0));
        chk("t5_err", 64'(bus_err_o), 64'(1));
        dm_req_i = 1'b0;
        tick();
        chk("t5_err_pulse", 64'(bus_err_o), 64'(0));

        // Asynchronous reset in the middle of a data transfer
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h300;
        tick();
        chk("t6_busy", 64'(bus_req_o), 64'(1));
        #2;
        idle_inputs();
        rst_i = 1'b0;
        #1;
        model_reset();
        check_regs();
        chk("t6_if_stall", 64'(if_stallreq_o), 64'(0));
        chk("t6_dm_stall", 64'(dm_stallreq_o), 64'(0));
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        tick();
        chk("t6_no_valid", 64'(dm_valid_o), 64'(0));
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_be_i = 4'hF; dm_addr_i = 32'h400;
        tick();
        chk("t6_req_c1", 64'(bus_req_o), 64'(1));
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0BAD_CAFE;
        tick();
        chk("t6_valid_c2", 64'(dm_valid_o), 64'(1));
        chk("t6_rdata", 64'(dm_rdata_o), 64'h0BAD_CAFE);
        idle_inputs();
        tick();

        // Random traffic: mostly prompt acks, then a slow bus that times out
        for (int i = 0; i < 600; i++) begin
            rand_inputs(60);
            tick();
        end
        for (int i = 0; i < 300; i++) begin
            rand_inputs(8);
            tick();
        end
        idle_inputs();
        repeat (12) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
